adaptive_filter_out_buf: RTL
============================

# adaptive_filter_out_buf

Output buffer placed directly downstream of `adaptive_filter`. The filter's result stream (`m_tdata`/`m_tvalid`) has no backpressure. This block stores those results in a small FIFO and re-issues them on an AXI-Stream-style master port with `tready` handshake. It also adds frame markers (`tlast`) every `FRAME_LEN` accepted samples and raises a sticky overflow flag when samples are dropped.

## Interface
Parameters:
- `WORDLENGTH`, 14: sample width in bits (Q8.6 signed, passed through unmodified).
- `DEPTH`, 16: FIFO depth in words; power of two, ≥ 2.
- `FRAME_LEN`, 128: accepted samples per frame; ≥ 2.

Ports:
- Clock and reset (already decided): one clock `clk`; reset `arst_n` is asynchronous and active-low.
- `clk`  in  1: single clock, rising edge.
- `arst_n`  in  1: asynchronous reset, active-low.
- `s_tdata`  in  WORDLENGTH: filter result (from `adaptive_filter.m_tdata`).
- `s_tvalid`  in  1: filter result valid; no ready is returned.
- `m_tdata`  out  WORDLENGTH: buffered sample.
- `m_tvalid`  out  1: buffered sample available.
- `m_tready`  in  1: downstream accepts.
- `m_tlast`  out  1: last sample of a frame.
- `fill_level`  out  $clog2(DEPTH)+1: number of words stored, 0..DEPTH.
- `overflow`  out  1: sticky flag, set when a sample is dropped.
- `clr_overflow`  in  1: synchronous clear of `overflow`.

## Operation
- Storage: a DEPTH-entry array of {tlast, tdata}, with wrapping read and write pointers ($clog2(DEPTH) bits) and a separate occupancy counter.
- Pop condition: `pop = m_tvalid && m_tready`.
- Push condition: `push = s_tvalid && (fill_level < DEPTH || pop)`.
  - When the FIFO is full, a write in the same cycle as a pop is accepted.
- Drop condition: `drop = s_tvalid && fill_level == DEPTH && !pop`.
  - The sample is discarded and `overflow` is set at the next edge.
- Occupancy update: `fill_level` changes by +push − pop each cycle; push and pop together leave it unchanged.
- Frame counter:
  - Counts pushed samples only, 0..FRAME_LEN−1.
  - A push at count FRAME_LEN−1 stores tlast=1 and wraps the count to 0.
  - Dropped samples do not advance the count.
- Output is first-word-fall-through:
  - `m_tvalid = (fill_level != 0)`.
  - `m_tdata = m_tvalid ? mem[rd_ptr].tdata : '0`.
  - `m_tlast = m_tvalid ? mem[rd_ptr].tlast : 0`.
- Handshake stability: while `m_tvalid && !m_tready`, `m_tdata` and `m_tlast` hold their values because `rd_ptr` does not move.
- `overflow`:
  - Set by `drop`; cleared by `clr_overflow`.
  - If both happen in the same cycle, set wins.
- No arithmetic on the data: the value is bit-exact with no sign or format change.

## Timing
- Reset state while `arst_n` = 0, applied immediately without waiting for a clock edge:
  - Pointers, `fill_level`, frame counter and `overflow` = 0.
  - Therefore `m_tvalid` = 0, `m_tdata` = 0, `m_tlast` = 0.
  - The memory array is not reset.
- Reset release: `arst_n` is deasserted synchronously to `clk` by the upstream synchronizer. The first push can occur at the first rising edge after deassertion.
- Latency: a sample pushed at edge N appears on `m_tvalid`/`m_tdata` after edge N, so it can be popped at edge N+1. Minimum latency is one cycle.
- Throughput: 1 sample/cycle when `m_tready` = 1 continuously. Under that condition `fill_level` never exceeds 1.
- Reset mid-stream: all stored samples are discarded and the frame restarts at count 0. Samples presented while `arst_n` = 0 are ignored.
- Pointer wrap: DEPTH−1 → 0 with no bubble.

## Test plan
- **Reset:** assert `arst_n` = 0 between clock edges → `m_tvalid`, `m_tlast`, `m_tdata`, `fill_level`, `overflow` all 0 before the next edge.
- **Pass-through:** `m_tready` = 1; push 0x0040, 0x3FC0, 0x1FFF on consecutive cycles → identical values on `m_tdata` one cycle later each, in order; `fill_level` ≤ 1; `overflow` = 0.
- **Backpressure and overflow:**
  - `m_tready` = 0; push 16 samples (values 1..16) → `fill_level` = 16, `overflow` = 0.
  - Push a 17th (0x0111) → dropped, `overflow` = 1 next cycle.
  - Set `m_tready` = 1 → 1..16 emitted in order; 0x0111 is never seen.
  - `overflow` stays 1 until `clr_overflow`.
- **Full with simultaneous pop:** FIFO full, `m_tready` = 1 and `s_tvalid` = 1 in the same cycle → sample accepted, `fill_level` stays 16, `overflow` stays 0. A simultaneous `clr_overflow` and `drop` → `overflow` = 1.
- **Framing:** `FRAME_LEN` = 4; push 10 samples with random `m_tready` gaps → `m_tlast` = 1 exactly on samples 4 and 8. `m_tdata`/`m_tlast` hold stable whenever `m_tvalid && !m_tready`.
- **Reset mid-operation:** `fill_level` = 5 with frame count 2; pulse `arst_n` low → `m_tvalid` drops immediately. After release, push 4 samples (`FRAME_LEN` = 4) → `m_tlast` on the 4th sample.

Source files
------------

// File: rtl/adaptive_filter_out_buf.sv
// ---------------------------------------------------------------------------
// adaptive_filter_out_buf
//
// Output buffer that sits directly after adaptive_filter. The filter result
// stream has no backpressure, so this block keeps the results in a small
// first-word-fall-through FIFO. It re-issues them on a ready/valid master
// port. Every FRAME_LEN accepted samples it marks the last sample with tlast.
// When a sample has to be discarded because the FIFO is full, it sets a
// sticky overflow flag.
//
// Parameters
//   WORDLENGTH : sample width (Q8.6 signed, passed through bit-exact)
//   DEPTH      : FIFO depth in words, power of two, >= 2
//   FRAME_LEN  : accepted samples per frame, >= 2
//
// Ports
//   clk          in   rising-edge clock
//   arst_n       in   asynchronous reset, active-low (deasserted synchronously)
//   s_tdata      in   filter result
//   s_tvalid     in   filter result valid (no ready is returned)
//   m_tdata      out  buffered sample (0 when m_tvalid is low)
//   m_tvalid     out  buffered sample available
//   m_tready     in   downstream accepts
//   m_tlast      out  last sample of a frame (0 when m_tvalid is low)
//   fill_level   out  number of stored words, 0..DEPTH
//   overflow     out  sticky flag, set when a sample is dropped
//   clr_overflow in   synchronous clear of overflow (a drop in the same cycle wins)
// ---------------------------------------------------------------------------
module adaptive_filter_out_buf #(
  parameter int WORDLENGTH = 14,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 128
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [WORDLENGTH-1:0]      s_tdata,
  input  logic                       s_tvalid,
  output logic [WORDLENGTH-1:0]      m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN);

  localparam logic [FW-1:0] FULL_LEVEL = FW'(DEPTH);
  localparam logic [CW-1:0] FRAME_END  = CW'(FRAME_LEN - 1);

  // Each entry is {tlast, tdata}. The frame marker is decided when the word
  // is written, so it always travels with its own sample.
  logic [WORDLENGTH:0] mem [DEPTH];

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       frame_cnt;
  logic [WORDLENGTH:0] rd_word;
  logic                full;
  logic                push;
  logic                pop;
  logic                drop;
  logic                wr_last;

  // Handshake decode. When the FIFO is full, a pop in the same cycle frees a
  // slot, so the incoming sample is still accepted.
  assign full     = (fill_level == FULL_LEVEL);
  assign m_tvalid = (fill_level != '0);
  assign pop      = m_tvalid && m_tready;
  assign push     = s_tvalid && (!full || pop);
  assign drop     = s_tvalid && full && !pop;
  assign wr_last  = (frame_cnt == FRAME_END);

  // First-word-fall-through read. rd_ptr only moves on pop, so the outputs
  // hold steady while the sink stalls. Outputs are forced to zero while the
  // FIFO is empty, so never-written memory does not show on the port.
  assign rd_word = mem[rd_ptr];
  assign m_tdata = m_tvalid ? rd_word[WORDLENGTH-1:0] : '0;
  assign m_tlast = m_tvalid ? rd_word[WORDLENGTH]     : 1'b0;

  // NOTE: the storage array has no reset. Words are never visible until
  // fill_level counts them, so clearing the array would only cost reset
  // fan-out and stop the tool from mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_last, s_tdata};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_level <= '0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        frame_cnt <= wr_last ? '0 : frame_cnt + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (push && !pop) begin
        fill_level <= fill_level + FW'(1);
      end else if (pop && !push) begin
        fill_level <= fill_level - FW'(1);
      end

      // A drop takes priority over a clear in the same cycle, so a loss is
      // never hidden.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
